// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read side and the output stream of fifo_stream_reader.
// The master modport is the reader; the slave modport is the FIFO plus the stream consumer.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 4
);
  logic                         fifo_empty;
  logic                         fifo_read;
  logic [DATA_WIDTH-1:0]        fifo_data;
  logic                         m_valid;
  logic                         m_ready;
  logic [DATA_WIDTH-1:0]        m_data;
  logic [$clog2(BUF_DEPTH):0]   buf_level;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_read, m_valid, m_data, buf_level
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_read, m_valid, m_data, buf_level
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Reads a block-RAM FIFO with a lagging empty flag and re-presents the words as a
// valid/ready stream through a small credit-managed circular buffer.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 2,
  parameter int FLAG_LAG   = 2,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.master bus
);

  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int LVL_W  = $clog2(BUF_DEPTH) + 1;
  localparam int INF_W  = $clog2(RD_LATENCY + 1);
  localparam int HOLD_W = $clog2(FLAG_LAG + 2);
  localparam int SPC_W  = $clog2(FLAG_LAG + 1);

  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [SPC_W-1:0]      spc_q, spc_d;
  logic                  rd_q, rd_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [INF_W-1:0]      inflight_q, inflight_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [LVL_W:0]        credit;

  // Stage: request issue, latency tracking and buffer bookkeeping
  always_comb begin
    pop    = (level_q != '0) && bus.m_ready;
    push   = vld_q[RD_LATENCY-1];
    // Outstanding words plus buffered words, net of the one leaving this edge
    credit = {1'b0, level_q} + (LVL_W+1)'(inflight_q) - (LVL_W+1)'(pop);
    issue  = (hold_q == '0) && !bus.fifo_empty && (spc_q == '0)
             && (credit < (LVL_W+1)'(BUF_DEPTH));

    rd_d   = issue;
    hold_d = (hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;
    if (issue)
      spc_d = SPC_W'(FLAG_LAG);
    else if (spc_q != '0)
      spc_d = spc_q - SPC_W'(1);
    else
      spc_d = spc_q;

    vld_d      = vld_q << 1;
    vld_d[0]   = rd_q;
    inflight_d = inflight_q + INF_W'(issue) - INF_W'(push);

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

    // Preload the next head word; bypass the capture when it lands at the head
    m_data_d = m_data_q;
    if (level_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d))
        m_data_d = bus.fifo_data;
      else
        m_data_d = mem_q[rd_ptr_d];
    end
  end

  // Stage: registered state
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= HOLD_W'(FLAG_LAG + 1);
      spc_q      <= '0;
      rd_q       <= 1'b0;
      vld_q      <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      m_data_q   <= '0;
    end else begin
      hold_q     <= hold_d;
      spc_q      <= spc_d;
      rd_q       <= rd_d;
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      m_data_q   <= m_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= bus.fifo_data;
  end

  assign bus.fifo_read = rd_q;
  assign bus.m_valid   = (level_q != '0);
  assign bus.m_data    = m_data_q;
  assign bus.buf_level = level_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model with read latency and lagging empty flag,
// directed scenarios, and a queue-based scoreboard checked by an independent monitor.
module tb_fifo_stream_reader;
  localparam int DW = 16;
  localparam int RL = 2;
  localparam int FL = 2;
  localparam int BD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) bus ();

  fifo_stream_reader #(
    .DATA_WIDTH(DW), .RD_LATENCY(RL), .FLAG_LAG(FL), .BUF_DEPTH(BD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q   [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: read data after RL edges, empty flag delayed through two registers
  logic [DW-1:0] stage_q;
  logic [DW-1:0] fdata_q;
  logic [1:0]    emp_pipe;
  assign bus.fifo_data  = fdata_q;
  assign bus.fifo_empty = emp_pipe[1];

  always @(posedge clk) begin
    if (bus.fifo_read === 1'b1) begin
      if (!rst) begin
        vectors++;
        if (model_q.size() == 0) begin
          miscompares++;
          $display("FAIL read_while_empty: fifo_read=1 with model occupancy 0 (t=%0t)", $time);
        end
      end
      stage_q <= (model_q.size() != 0) ? model_q.pop_front() : 16'hDEAD;
    end
    fdata_q <= stage_q;
    if (rst) emp_pipe <= 2'b00;
    else     emp_pipe <= {emp_pipe[0], (model_q.size() == 0)};
  end

  // Monitor: values seen at negedge are those the next rising edge acts on
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_valid", 32'(bus.m_valid), 32'd1);
      check("stall_data", 32'(bus.m_data), 32'(prev_data));
    end
    vectors++;
    if (bus.buf_level > BD) begin
      miscompares++;
      $display("FAIL buf_overflow: buf_level=%0d, limit %0d", bus.buf_level, BD);
    end
    if (!rst && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: got %h, expected no word", bus.m_data);
      end else begin
        check("stream_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
      end
    end
    prev_stall = !rst && bus.m_valid && !bus.m_ready;
    prev_data  = bus.m_data;
  end

  // Read spacing watcher
  int cyc     = 0;
  int last_rd = -1;
  int rd_cnt  = 0;
  logic spc_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (spc_en && bus.fifo_read) begin
      if (last_rd >= 0) check("read_spacing", 32'(cyc - last_rd), 32'd3);
      last_rd = cyc;
      rd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    model_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || bus.buf_level != 0) && n < bound) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || bus.buf_level != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d words outstanding, buf_level %0d, expected 0",
               exp_q.size(), bus.buf_level);
    end
  endtask

  initial begin
    int r;
    logic found;
    bus.m_ready = 1'b1;
    rst = 1'b1;
    push(16'hA5A5);

    // Reset state, startup hold and single word
    tick();
    check("rst_fifo_read", 32'(bus.fifo_read), 32'd0);
    check("rst_m_valid",   32'(bus.m_valid),   32'd0);
    check("rst_m_data",    32'(bus.m_data),    32'd0);
    check("rst_buf_level", 32'(bus.buf_level), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("hold_fifo_read", 32'(bus.fifo_read), 32'd0);
      check("hold_m_valid",   32'(bus.m_valid),   32'd0);
    end
    tick();
    check("first_read", 32'(bus.fifo_read), 32'd1);
    tick();
    check("read_pulse_width", 32'(bus.fifo_read), 32'd0);
    tick();
    check("pre_capture_valid", 32'(bus.m_valid), 32'd0);
    tick();
    check("single_valid", 32'(bus.m_valid), 32'd1);
    check("single_data",  32'(bus.m_data),  32'hA5A5);
    tick();
    check("single_one_cycle", 32'(bus.m_valid), 32'd0);
    check("single_no_reread", 32'(bus.fifo_read), 32'd0);

    // Streaming at full rate
    last_rd = -1;
    rd_cnt  = 0;
    spc_en  = 1'b1;
    for (int i = 1; i <= 16; i++) push(DW'(i));
    drain(200);
    spc_en = 1'b0;
    check("stream_read_count", 32'(rd_cnt), 32'd16);

    // Backpressure
    bus.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(16'h0100 + DW'(i));
    repeat (40) tick();
    check("bp_level",   32'(bus.buf_level), 32'd4);
    check("bp_valid",   32'(bus.m_valid),   32'd1);
    check("bp_head",    32'(bus.m_data),    32'h0100);
    r = 0;
    repeat (10) begin
      tick();
      if (bus.fifo_read) r++;
    end
    check("bp_no_reads", 32'(r), 32'd0);
    bus.m_ready = 1'b1;
    drain(300);

    // Random backpressure and writes
    for (int c = 0; c < 2000; c++) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) push(DW'($urandom));
      tick();
    end
    bus.m_ready = 1'b1;
    drain(2000);

    // Reset with one read in flight and three words buffered
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(16'h0300 + DW'(i));
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      tick();
      if (bus.buf_level == 3 && bus.fifo_read) found = 1'b1;
    end
    check("mid_setup_reached", 32'(found), 32'd1);
    rst = 1'b1;
    model_q.delete();
    exp_q.delete();
    tick();
    check("mid_rst_valid", 32'(bus.m_valid),   32'd0);
    check("mid_rst_level", 32'(bus.buf_level), 32'd0);
    check("mid_rst_read",  32'(bus.fifo_read), 32'd0);
    rst = 1'b0;
    push(16'h0400);
    push(16'h0401);
    bus.m_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("mid_hold_read",    32'(bus.fifo_read), 32'd0);
      check("mid_no_capture",   32'(bus.m_valid),   32'd0);
    end
    tick();
    check("mid_first_read", 32'(bus.fifo_read), 32'd1);
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
